// File: rtl/nibble_subtractor.sv
// Serial subtractor: one 4-bit lookahead slice per clock, LSB slice first.
// Define SUB_OVERFLOW_EN to add a signed-overflow output.
module nibble_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SUB_OVERFLOW_EN
    output logic             borrow_out,
    output logic             overflow
`else
    output logic             borrow_out
`endif
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]   idx;
    logic            carry;
    logic            last;
    logic            accept;
    logic [3:0]      sa, sb, g, p, sum;
    logic [4:0]      c;

    assign last   = (idx == IW'(NIB - 1));
    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // a - b computed as a + ~b + 1, carry threaded between slices
    always_comb begin
        sa   = a_q[4*idx +: 4];
        sb   = b_q[4*idx +: 4];
        g    = sa & ~sb;
        p    = sa ^ ~sb;
        c    = '0;
        c[0] = carry;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum = p ^ c[3:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            idx        <= '0;
            carry      <= 1'b1;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= '0;
            carry <= 1'b1;
        end else if (state == RUN) begin
            diff[4*idx +: 4] <= sum;
            carry            <= c[4];
            if (last) begin
                idx        <= '0;
                borrow_out <= ~c[4];
`ifdef SUB_OVERFLOW_EN
                overflow   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (sum[3] != a_q[WIDTH-1]);
`endif
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_nibble_subtractor.sv
// Directed self-checking bench for nibble_subtractor (WIDTH=16).
// Overflow checks are included when SUB_OVERFLOW_EN is defined.
module tb_nibble_subtractor;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a, b;
    logic        busy, done;
    logic [15:0] diff;
    logic        borrow_out;
`ifdef SUB_OVERFLOW_EN
    logic        overflow;
`endif

    int compared = 0;
    int mismatched = 0;

    nibble_subtractor #(.WIDTH(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
`ifdef SUB_OVERFLOW_EN
        .borrow_out (borrow_out),
        .overflow   (overflow)
`else
        .borrow_out (borrow_out)
`endif
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; returns positioned in the done cycle (or timeout).
    task automatic run_op(input string tag, input logic [15:0] va,
                          input logic [15:0] vb, input logic [15:0] ed,
                          input logic eb);
        int nb;
        int n;
        a = va;
        b = vb;
        start = 1'b1;
        step();
        start = 1'b0;
        nb = 0;
        n = 0;
        while (!done && n < 20) begin
            if (busy) nb++;
            step();
            n++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busycyc"}, nb, 32'd4);
        chk({tag, "_diff"}, {16'd0, diff}, {16'd0, ed});
        chk({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, eb});
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {16'd0, diff}, 32'd0);
        chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
`ifdef SUB_OVERFLOW_EN
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
`endif
        reset = 1'b0;
        step();

        run_op("basic", 16'h1234, 16'h0234, 16'h1000, 1'b0);
        step();
        chk("basic_idle_done", {31'd0, done}, 32'd0);
        chk("basic_idle_busy", {31'd0, busy}, 32'd0);
        chk("basic_hold", {16'd0, diff}, 32'h1000);

        run_op("under", 16'h0000, 16'h0001, 16'hFFFF, 1'b1);
`ifdef SUB_OVERFLOW_EN
        chk("under_ovf", {31'd0, overflow}, 32'd0);
`endif
        step();

        run_op("sgn", 16'h8000, 16'h0001, 16'h7FFF, 1'b0);
`ifdef SUB_OVERFLOW_EN
        chk("sgn_ovf", {31'd0, overflow}, 32'd1);
`endif
        step();

        // Start held through RUN with different operands must be ignored
        a = 16'h00FF;
        b = 16'h0001;
        start = 1'b1;
        step();
        a = 16'hFFFF;
        b = 16'h0000;
        step();
        step();
        step();
        step();
        start = 1'b0;
        chk("ign_done", {31'd0, done}, 32'd1);
        chk("ign_diff", {16'd0, diff}, 32'h00FE);
        chk("ign_borrow", {31'd0, borrow_out}, 32'd0);
        step();
        chk("ign_idle_busy", {31'd0, busy}, 32'd0);
        chk("ign_idle_done", {31'd0, done}, 32'd0);
        chk("ign_hold", {16'd0, diff}, 32'h00FE);

        // Reset in the second RUN cycle
        a = 16'h1234;
        b = 16'h0234;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_diff", {16'd0, diff}, 32'd0);
        chk("mrst_borrow", {31'd0, borrow_out}, 32'd0);
        run_op("post", 16'h0005, 16'h0003, 16'h0002, 1'b0);

        // Back-to-back: accept in the DONE cycle
        a = 16'h0010;
        b = 16'h0020;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        n = 1;
        while (!done && n < 20) begin
            step();
            n++;
        end
        chk("b2b_gap", n, 32'd5);
        chk("b2b_diff", {16'd0, diff}, 32'hFFF0);
        chk("b2b_borrow", {31'd0, borrow_out}, 32'd1);
        step();
        chk("b2b_idle", {31'd0, done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
